// File: rtl/sum_accumulator_if.sv
// sum_accumulator_if
//   Valid/ready bundle for sum_accumulator. It carries two handshakes.
//   Upstream side (beats in):
//     valid_i - beat valid
//     ready_o - the block can take a beat this cycle
//     data_i  - unsigned beat value, width_p bits
//   Downstream side (totals out):
//     valid_o - total valid
//     ready_i - the consumer takes the total
//     data_o  - unsigned group total, out_width_lp bits
//   Modports:
//     slave  - the accumulator's view of the bundle
//     master - the view of whatever drives beats and consumes totals
interface sum_accumulator_if #(
    parameter int width_p = 33,
    parameter int count_p = 4
);
    localparam int out_width_lp = width_p + $clog2(count_p);

    logic                    valid_i;
    logic                    ready_o;
    logic [width_p-1:0]      data_i;
    logic                    valid_o;
    logic                    ready_i;
    logic [out_width_lp-1:0] data_o;

    modport slave (
        input  valid_i, data_i, ready_i,
        output ready_o, valid_o, data_o
    );

    modport master (
        output valid_i, data_i, ready_i,
        input  ready_o, valid_o, data_o
    );
endinterface

// File: rtl/sum_accumulator.sv
// sum_accumulator
//   Sink for the adder stage's sum stream. The block adds every group of
//   count_p accepted beats and emits one widened, registered total per
//   group. Both sides use valid/ready handshakes.
//   Ports:
//     clk_i   - clock; all state changes on the rising edge
//     reset_i - synchronous reset, active-high
//     bus     - sum_accumulator_if.slave; beats come in on valid_i,
//               ready_o and data_i; totals go out on valid_o, ready_i
//               and data_o
module sum_accumulator #(
    parameter int width_p = 33,
    parameter int count_p = 4
) (
    input  logic             clk_i,
    input  logic             reset_i,
    sum_accumulator_if.slave bus
);
    // Adding count_p values of width_p bits needs $clog2(count_p) extra
    // bits, so a total can never wrap.
    localparam int out_width_lp = width_p + $clog2(count_p);
    localparam int cnt_width_lp = (count_p > 1) ? $clog2(count_p) : 1;
    localparam logic [cnt_width_lp-1:0] last_cnt_lp = cnt_width_lp'(count_p - 1);

    function automatic logic [out_width_lp-1:0] zext(input logic [width_p-1:0] v);
        return out_width_lp'(v);
    endfunction

    logic [out_width_lp-1:0] acc_r;
    logic [out_width_lp-1:0] data_r;
    logic [cnt_width_lp-1:0] cnt_r;
    logic                    valid_r;

    logic                    is_last;
    logic                    ready;
    logic                    accept;
    logic                    consume;
    logic [out_width_lp-1:0] sum_next;

    always_comb begin
        is_last  = (cnt_r == last_cnt_lp);
        // Only the final beat of a group needs the output register free,
        // so partial beats keep flowing while a total is held. This signal
        // never looks at valid_i, which keeps the handshake loop-free.
        ready    = ~is_last | ~valid_r | bus.ready_i;
        accept   = bus.valid_i & ready;
        consume  = valid_r & bus.ready_i;
        // The first beat of a group starts a fresh sum, so acc_r never has
        // to be cleared between groups.
        sum_next = (cnt_r == '0) ? zext(bus.data_i) : acc_r + zext(bus.data_i);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            acc_r   <= '0;
            data_r  <= '0;
            cnt_r   <= '0;
            valid_r <= 1'b0;
        end else begin
            if (consume) begin
                valid_r <= 1'b0;
            end
            if (accept) begin
                if (is_last) begin
                    // A final beat in the same cycle as a consume sets
                    // valid again here. That keeps the output full with no
                    // bubble between totals.
                    data_r  <= sum_next;
                    valid_r <= 1'b1;
                    cnt_r   <= '0;
                end else begin
                    acc_r   <= sum_next;
                    cnt_r   <= cnt_r + cnt_width_lp'(1);
                end
            end
        end
    end

    assign bus.ready_o = ready;
    assign bus.valid_o = valid_r;
    assign bus.data_o  = data_r;

endmodule
